// File: rtl/psychic5_frame_capture_if.sv
// Pixel-stream bus between the video core (master) and the frame capture block (slave).
// Carries the qualified input stream plus the per-pixel and per-frame capture results.
interface psychic5_frame_capture_if #(
    parameter int CBITS  = 4,
    parameter int FCNT_W = 8
);
    logic                  i_EMU_CLK6MPCEN_n;
    logic [8:0]            i_HCOUNTER;
    logic [8:0]            i_VCOUNTER;
    logic [3*CBITS-1:0]    i_VIDEODATA;

    logic                  o_PIX_VALID;
    logic [8:0]            o_PIX_X;
    logic [8:0]            o_PIX_Y;
    logic [3*CBITS-1:0]    o_PIX_DATA;
    logic                  o_FRAME_DONE;
    logic [FCNT_W-1:0]     o_FRAME_CNT;
    logic [16:0]           o_FRAME_PIXCNT;
    logic [15:0]           o_FRAME_CRC;
    logic                  o_SYNC_ERR;

    modport master (
        output i_EMU_CLK6MPCEN_n, i_HCOUNTER, i_VCOUNTER, i_VIDEODATA,
        input  o_PIX_VALID, o_PIX_X, o_PIX_Y, o_PIX_DATA,
        input  o_FRAME_DONE, o_FRAME_CNT, o_FRAME_PIXCNT, o_FRAME_CRC, o_SYNC_ERR
    );

    modport slave (
        input  i_EMU_CLK6MPCEN_n, i_HCOUNTER, i_VCOUNTER, i_VIDEODATA,
        output o_PIX_VALID, o_PIX_X, o_PIX_Y, o_PIX_DATA,
        output o_FRAME_DONE, o_FRAME_CNT, o_FRAME_PIXCNT, o_FRAME_CRC, o_SYNC_ERR
    );
endinterface

// File: rtl/psychic5_frame_capture.sv
// Windowed frame capture of the Psychic 5 pixel stream with per-frame count/CRC/done.
// Define FRAME_CAPTURE_CRC_EN to include the CRC-16-CCITT; otherwise o_FRAME_CRC is 0.
module psychic5_frame_capture #(
    parameter int CBITS   = 4,
    parameter int H_START = 0,
    parameter int H_END   = 255,
    parameter int V_START = 16,
    parameter int V_END   = 239,
    parameter int FCNT_W  = 8
) (
    input  logic                   i_EMU_MCLK,
    input  logic                   i_EMU_MRST,
    psychic5_frame_capture_if.slave bus
);
    localparam int PW = 3 * CBITS;

    generate
        if (PW > 16) begin : g_bad_cbits
            $error("psychic5_frame_capture: 3*CBITS exceeds 16");
        end
        if (H_START > H_END || V_START > V_END) begin : g_bad_window
            $error("psychic5_frame_capture: empty active window");
        end
    endgenerate

    localparam logic [8:0] H_S    = 9'(H_START);
    localparam logic [8:0] V_S    = 9'(V_START);
    localparam logic [8:0] H_SPAN = 9'(H_END - H_START);
    localparam logic [8:0] V_SPAN = 9'(V_END - V_START);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]        state;
    logic [16:0]       cnt_run;
    logic              pix_valid, frame_done, sync_err;
    logic [8:0]        pix_x, pix_y;
    logic [PW-1:0]     pix_data;
    logic [FCNT_W-1:0] frame_cnt;
    logic [16:0]       frame_pixcnt;
    logic [15:0]       frame_crc;

    // Offsets wrap modulo 512, so a counter below the window start lands above the span.
    logic [8:0] x_off, y_off;
    logic       sample, in_h, in_v, start, take, abort, last;

    assign x_off  = bus.i_HCOUNTER - H_S;
    assign y_off  = bus.i_VCOUNTER - V_S;
    assign sample = !bus.i_EMU_CLK6MPCEN_n;
    assign in_h   = (x_off <= H_SPAN);
    assign in_v   = (y_off <= V_SPAN);
    assign start  = sample && (state == IDLE) && (x_off == 9'd0) && (y_off == 9'd0);
    assign abort  = sample && (state == CAPTURE) && !in_v;
    assign take   = start || (sample && (state == CAPTURE) && in_v && in_h);
    assign last   = take && (x_off == H_SPAN) && (y_off == V_SPAN);

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_MRST) begin
            state        <= IDLE;
            cnt_run      <= '0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_data     <= '0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            frame_pixcnt <= '0;
            sync_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees the pre-edge values of its peers.
            pix_valid  <= take;
            frame_done <= (state == DONE);
            if (take) begin
                pix_x    <= x_off;
                pix_y    <= y_off;
                pix_data <= bus.i_VIDEODATA;
                cnt_run  <= start ? 17'd1 : cnt_run + 17'd1;
            end
            if (abort)
                sync_err <= 1'b1;
            if (state == DONE) begin
                frame_pixcnt <= cnt_run;
                frame_cnt    <= frame_cnt + 1'b1;
            end
            case (state)
                IDLE:    if (start) state <= last ? DONE : CAPTURE;
                CAPTURE: if (abort) state <= IDLE;
                         else if (last) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_CAPTURE_CRC_EN
    logic [15:0] crc_run;

    // CRC-16-CCITT, MSB first, whole 16-bit word folded in a single cycle.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_MRST) begin
            crc_run   <= 16'hFFFF;
            frame_crc <= 16'h0000;
        end else begin
            if (take)
                crc_run <= crc_step(start ? 16'hFFFF : crc_run, 16'(bus.i_VIDEODATA));
            if (state == DONE)
                frame_crc <= crc_run;
        end
    end
`else
    assign frame_crc = 16'h0000;
`endif

    assign bus.o_PIX_VALID    = pix_valid;
    assign bus.o_PIX_X        = pix_x;
    assign bus.o_PIX_Y        = pix_y;
    assign bus.o_PIX_DATA     = pix_data;
    assign bus.o_FRAME_DONE   = frame_done;
    assign bus.o_FRAME_CNT    = frame_cnt;
    assign bus.o_FRAME_PIXCNT = frame_pixcnt;
    assign bus.o_FRAME_CRC    = frame_crc;
    assign bus.o_SYNC_ERR     = sync_err;
endmodule
